seven_segment_scanner: RTL and testbench
========================================

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed hex digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; must be at least 2.
REQ-003 Parameter BLANK_CYCLES, default 2: cycles at the start of each slot with all digits off; must be less than SCAN_DIV.
REQ-004 Port clk, input, 1 bit: the block's single clock; all state is clocked on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port enable, input, 1 bit: 1 = scanning display on; 0 = all segments and digits off.
REQ-007 Port load, input, 1 bit: single-cycle strobe that captures value_in.
REQ-008 Port value_in, input, 4*NUM_DIGITS bits: hex nibbles, with digit 0 in bits [3:0].
REQ-009 Port seg_out, output, 7 bits: active-low segments, bit 0 = a through bit 6 = g.
REQ-010 Port digit_sel, output, NUM_DIGITS bits: active-low one-hot digit enable.
REQ-011 Port slot_tick, output, 1 bit: one-cycle pulse on the cycle the digit index advances.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; index advances on wrap, NUM_DIGITS-1 wraps to 0.
REQ-013 slot_tick SHALL be 1 exactly in the cycle the prescaler holds SCAN_DIV-1.
REQ-014 load=1 at a clock edge SHALL copy value_in into the display register at that edge; no effect when load=0.
REQ-015 Outputs SHALL be registered with one-cycle latency from the prescaler/index/display-register state.
REQ-016 While prescaler < BLANK_CYCLES, digit_sel SHALL be all ones and seg_out 7'b1111111 (anti-ghosting).
REQ-017 Otherwise, digit_sel bit[index] SHALL be 0 and all other bits 1.
REQ-018 Otherwise, seg_out SHALL be the decode of nibble[index].
REQ-019 Decode table (gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-020 Decode table continued: 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 enable=0 SHALL force both outputs to all ones one cycle later; prescaler and index keep running.
REQ-022 load coinciding with a slot change: the new slot SHALL show the newly loaded value.
REQ-023 NUM_DIGITS=1: the index SHALL stay 0 and slot_tick SHALL still pulse.

Reset
REQ-024 rst_n low SHALL immediately clear prescaler, index and display register to 0.
REQ-025 rst_n low SHALL immediately set seg_out = 7'b1111111, digit_sel all ones and slot_tick = 0.
REQ-026 After rst_n release, the first edge SHALL start slot 0 with prescaler 0; reset mid-slot abandons that slot.

Configuration
REQ-027 Macro SEG_LEADING_ZERO_BLANK_EN defined: a digit SHALL show 7'b1111111 with its digit_sel still asserted when it and every higher digit are 0.
REQ-028 Under SEG_LEADING_ZERO_BLANK_EN, digit 0 SHALL always be displayed.
REQ-029 Macro SEG_LEADING_ZERO_BLANK_EN undefined: every digit SHALL be decoded, including leading zeros.

Structure
REQ-030 Shared package seg_pkg SHALL hold the SEG_BLANK constant (7'b1111111) and the 16-entry decode constant table.
REQ-031 Sub-module seg_digit_decode (4-bit nibble to 7-bit active-low segments, combinational) SHALL be used once on the selected nibble.

Verification (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2)
REQ-032 Reset then load 16'h12AF -> cycle by cycle: digit_sel 1111 for 2 cycles, then 1110 with seg 0001110 (F) for 6 cycles, then the same pattern with 1101/0001000 (A).
REQ-033 Run 32+ cycles -> digit order 0,1,2,3,0, one slot_tick every 8 cycles, never more than one digit_sel bit low.
REQ-034 Load 16'h0005 -> with SEG_LEADING_ZERO_BLANK_EN, digits 3..1 give seg 1111111 and digit 0 gives 0010010; without the macro, digits 3..1 give 1000000.
REQ-035 enable=0 for 20 cycles, then 1 -> outputs all ones during the gap, then resume at the correct index with no slot restart.
REQ-036 Assert rst_n low mid-slot 2 -> outputs all ones immediately, asynchronously; after release, the scan restarts at slot 0 showing 0.
REQ-037 Load 16'hBEEF in the slot_tick cycle -> the next slot shows nibbles of 16'hBEEF.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: blank pattern and hex decode table.
// Segment order is gfedcba, active-low.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry 15 is leftmost so that SEG_TABLE[n] yields the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg_digit_decode.sv
// Purpose: hex nibble to active-low seven-segment pattern (gfedcba).
// Latency: combinational.
// Backpressure: none.
module seg_digit_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_segment_scanner.sv
// Purpose: time-multiplexed hex display scanner; SEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: outputs registered one cycle behind prescaler/index/display state.
// Backpressure: none; load is a fire-and-forget strobe, scanning free-runs.
module seven_segment_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    slot_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_PRE  = PW'(SCAN_DIV - 2);
    localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]                presc;
    logic [IW-1:0]                idx;
    logic [NUM_DIGITS-1:0][3:0]   disp;
    logic [3:0]                   nibble_sel;
    logic [6:0]                   seg_dec;
    logic [NUM_DIGITS-1:0]        sel_n;
    logic                         lz_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
            disp  <= '0;
        end else begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (load) begin
                disp <= value_in;
            end
        end
    end

    assign nibble_sel = disp[idx];

    seg_digit_decode u_decode (
        .nibble (nibble_sel),
        .seg    (seg_dec)
    );

    always_comb begin
        sel_n = '1;
        sel_n[idx] = 1'b0;
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // zero_up[i] is set when digit i and every digit above it are zero.
    logic [NUM_DIGITS-1:0] zero_up;
    logic                  zero_acc;

    always_comb begin
        zero_acc = 1'b1;
        zero_up  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_acc   = zero_acc & (disp[i] == 4'h0);
            zero_up[i] = zero_acc;
        end
    end

    assign lz_blank = (idx != '0) && zero_up[idx];
`else
    assign lz_blank = 1'b0;
`endif

    // slot_tick is registered from the pre-wrap count so it is high while the prescaler holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out   <= SEG_BLANK;
            digit_sel <= '1;
            slot_tick <= 1'b0;
        end else begin
            slot_tick <= (presc == PRESC_PRE);
            if (!enable || (presc < BLANK_LIM)) begin
                seg_out   <= SEG_BLANK;
                digit_sel <= '1;
            end else begin
                seg_out   <= lz_blank ? SEG_BLANK : seg_dec;
                digit_sel <= sel_n;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner at NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seven_segment_scanner;

    localparam logic [6:0] S_0 = 7'b1000000;
    localparam logic [6:0] S_1 = 7'b1111001;
    localparam logic [6:0] S_2 = 7'b0100100;
    localparam logic [6:0] S_5 = 7'b0010010;
    localparam logic [6:0] S_A = 7'b0001000;
    localparam logic [6:0] S_B = 7'b0000011;
    localparam logic [6:0] S_E = 7'b0000110;
    localparam logic [6:0] S_F = 7'b0001110;
    localparam logic [6:0] S_OFF = 7'b1111111;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] S_LZ = S_OFF;
`else
    localparam logic [6:0] S_LZ = S_0;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value_in;
    logic [6:0]  seg_out;
    logic [3:0]  digit_sel;
    logic        slot_tick;

    int checks = 0;
    int errors = 0;
    int k = 0;

    seven_segment_scanner #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load      (load),
        .value_in  (value_in),
        .seg_out   (seg_out),
        .digit_sel (digit_sel),
        .slot_tick (slot_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  sel;
        logic [6:0]  seg;
        logic        tick;
    } vec_t;

    vec_t tbl [40];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, k);
        end
    endtask

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    initial begin
        logic [6:0] dseg [4];
        int s;
        int p;

        // Scan of 16'h12AF: digit 0 = F, 1 = A, 2 = 2, 3 = 1.
        dseg[0] = S_F;
        dseg[1] = S_A;
        dseg[2] = S_2;
        dseg[3] = S_1;
        for (int i = 0; i < 40; i++) begin
            s = (i / 8) % 4;
            p = i % 8;
            tbl[i].en   = 1'b1;
            tbl[i].ld   = (i == 0);
            tbl[i].val  = 16'h12AF;
            tbl[i].sel  = (p < 2) ? 4'b1111 : ~(4'b0001 << s);
            tbl[i].seg  = (p < 2) ? S_OFF : dseg[s];
            tbl[i].tick = ((i + 1) % 8 == 7);
        end

        rst_n    = 1'b0;
        enable   = 1'b1;
        load     = 1'b0;
        value_in = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_seg", seg_out, S_OFF);
        chk("reset_sel", digit_sel, 4'b1111);
        chk("reset_tick", slot_tick, 1'b0);

        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            enable   = tbl[i].en;
            load     = tbl[i].ld;
            value_in = tbl[i].val;
            step();
            chk("scan_sel", digit_sel, tbl[i].sel);
            chk("scan_seg", seg_out, tbl[i].seg);
            chk("scan_tick", slot_tick, tbl[i].tick);
            chk("scan_onehot", ($countones(~digit_sel) <= 1), 1'b1);
        end
        load = 1'b0;

        // Display gated off for 20 cycles; prescaler keeps ticking underneath.
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("gap_sel", digit_sel, 4'b1111);
            chk("gap_seg", seg_out, S_OFF);
            chk("gap_tick", slot_tick, (k % 8 == 7));
        end
        enable = 1'b1;
        step();
        chk("resume_sel", digit_sel, 4'b0111);
        chk("resume_seg", seg_out, S_1);
        run_to(65);
        chk("resume_blank", digit_sel, 4'b1111);
        run_to(67);
        chk("resume_d0_sel", digit_sel, 4'b1110);
        chk("resume_d0_seg", seg_out, S_F);

        // Load in the slot_tick cycle: old value holds to slot end, new slot shows BEEF.
        run_to(71);
        chk("beef_tick", slot_tick, 1'b1);
        chk("beef_old_seg", seg_out, S_F);
        load     = 1'b1;
        value_in = 16'hBEEF;
        step();
        load = 1'b0;
        chk("beef_latency_seg", seg_out, S_F);
        run_to(75);
        chk("beef_d1_sel", digit_sel, 4'b1101);
        chk("beef_d1_seg", seg_out, S_E);
        run_to(91);
        chk("beef_d3_sel", digit_sel, 4'b0111);
        chk("beef_d3_seg", seg_out, S_B);

        // Leading zeros.
        run_to(96);
        load     = 1'b1;
        value_in = 16'h0005;
        step();
        load = 1'b0;
        run_to(99);
        chk("lz_d0_sel", digit_sel, 4'b1110);
        chk("lz_d0_seg", seg_out, S_5);
        run_to(107);
        chk("lz_d1_sel", digit_sel, 4'b1101);
        chk("lz_d1_seg", seg_out, S_LZ);
        run_to(123);
        chk("lz_d3_sel", digit_sel, 4'b0111);
        chk("lz_d3_seg", seg_out, S_LZ);

        // Inner zero below a nonzero digit is always drawn.
        run_to(124);
        load     = 1'b1;
        value_in = 16'h0105;
        step();
        load = 1'b0;
        run_to(127);
        chk("inner_d3_seg", seg_out, S_LZ);
        run_to(139);
        chk("inner_d1_sel", digit_sel, 4'b1101);
        chk("inner_d1_seg", seg_out, S_0);

        // Asynchronous reset in the middle of slot 2.
        run_to(149);
        chk("mid_d2_sel", digit_sel, 4'b1011);
        chk("mid_d2_seg", seg_out, S_1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_sel", digit_sel, 4'b1111);
        chk("async_seg", seg_out, S_OFF);
        chk("async_tick", slot_tick, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        step();
        chk("restart_blank", digit_sel, 4'b1111);
        chk("restart_tick0", slot_tick, 1'b0);
        run_to(3);
        chk("restart_sel", digit_sel, 4'b1110);
        chk("restart_seg", seg_out, S_0);
        run_to(7);
        chk("restart_tick", slot_tick, 1'b1);
        run_to(11);
        chk("restart_d1_sel", digit_sel, 4'b1101);
        chk("restart_d1_seg", seg_out, S_LZ);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
